// File: rtl/tag_computer_led_ctrl.sv
// Memory-mapped LED/channel controller with set/clear/toggle access and a per-channel blink gate.
// The blink gate is driven by a free-running prescaler that reloads from PERIOD.
module tag_computer_led_ctrl #(
  parameter int unsigned      WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      PRESCALE_W  = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic [2:0] {
    REG_DATA     = 3'd0,
    REG_SET      = 3'd1,
    REG_CLR      = 3'd2,
    REG_TOGGLE   = 3'd3,
    REG_BLINK_EN = 3'd4,
    REG_PERIOD   = 3'd5,
    REG_STATUS   = 3'd6,
    REG_RSVD     = 3'd7
  } reg_addr_e;

  reg_addr_e              addr;
  logic                   wr;
  logic [WIDTH-1:0]       wd_data;
  logic [PRESCALE_W-1:0]  wd_period;
  logic                   unused_wd;

  logic [WIDTH-1:0]       data_q, data_d;
  logic [WIDTH-1:0]       blink_en_q, blink_en_d;
  logic [PRESCALE_W-1:0]  period_q, period_d;
  logic [PRESCALE_W-1:0]  cnt_q, cnt_d;
  logic                   phase_q, phase_d;
  logic [WIDTH-1:0]       out_q, out_d;

  assign addr      = reg_addr_e'(address);
  assign wr        = chipselect & ~write_n;
  assign wd_data   = writedata[WIDTH-1:0];
  assign wd_period = writedata[PRESCALE_W-1:0];
  assign unused_wd = ^writedata;
  assign out_port  = out_q;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    readdata = '0;
    case (addr)
      REG_DATA:     readdata[WIDTH-1:0]      = data_q;
      REG_BLINK_EN: readdata[WIDTH-1:0]      = blink_en_q;
      REG_PERIOD:   readdata[PRESCALE_W-1:0] = period_q;
      REG_STATUS:   readdata[0]              = phase_q;
      default:      readdata                 = '0;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;

    if (wr) begin
      case (addr)
        REG_DATA:     data_d     = wd_data;
        REG_SET:      data_d     = data_q | wd_data;
        REG_CLR:      data_d     = data_q & ~wd_data;
        REG_TOGGLE:   data_d     = data_q ^ wd_data;
        REG_BLINK_EN: blink_en_d = wd_data;
        REG_PERIOD:   period_d   = wd_period;
        default:      ;
      endcase
    end

    // A PERIOD write restarts the count from the new value; zero parks the prescaler.
    if (wr && addr == REG_PERIOD) begin
      cnt_d   = wd_period;
      phase_d = 1'b0;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d   = period_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q - PRESCALE_W'(1);
    end

    out_d = data_q & (~blink_en_q | {WIDTH{phase_q}});
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      out_q      <= RESET_VALUE;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_tag_computer_led_ctrl.sv
// Randomized bench for tag_computer_led_ctrl; the reference derives blink phase arithmetically
// from the edge count since the last PERIOD write.
module tb_tag_computer_led_ctrl;

  localparam int W  = 10;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0]  m_data, m_blink, m_out;
  logic [PW-1:0] m_per;
  longint        n_edge = 0;
  longint        t0 = 0;

  tag_computer_led_ctrl #(
    .WIDTH      (W),
    .RESET_VALUE('0),
    .PRESCALE_W (PW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  // Phase flips once every PERIOD+1 edges, counted from the edge of the last PERIOD write.
  function automatic logic m_phase();
    if (m_per == '0) return 1'b0;
    return (((n_edge - t0) / (longint'(m_per) + 1)) % 2) != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0:    r[W-1:0]  = m_data;
      3'd4:    r[W-1:0]  = m_blink;
      3'd5:    r[PW-1:0] = m_per;
      3'd6:    r[0]      = m_phase();
      default: r         = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_blink = '0;
    m_per   = '0;
    m_out   = '0;
  endtask

  task automatic cycle(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    logic [W-1:0] wv;
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    @(posedge clk);
    wv    = wd[W-1:0];
    m_out = m_data & (~m_blink | {W{m_phase()}});
    n_edge++;
    if (cs && !wn) begin
      case (a)
        3'd0: m_data  = wv;
        3'd1: m_data  = m_data | wv;
        3'd2: m_data  = m_data & ~wv;
        3'd3: m_data  = m_data ^ wv;
        3'd4: m_blink = wv;
        3'd5: begin m_per = wd[PW-1:0]; t0 = n_edge; end
        default: ;
      endcase
    end
    #1;
    check("out_port", {{(32-W){1'b0}}, out_port}, {{(32-W){1'b0}}, m_out});
    check($sformatf("readdata[a=%0d]", a), readdata, m_read(a));
  endtask

  task automatic idle(input int n, input logic [2:0] a);
    for (int i = 0; i < n; i++) cycle(a, 1'b0, 1'b1, $urandom);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    model_reset();

    // Reads during reset and after release: everything zero.
    #2;
    check("out_port_in_reset", {22'b0, out_port}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      check($sformatf("reset_read[a=%0d]", a), readdata, 32'h0);
    end
    #10 reset_n = 1'b1;
    for (int a = 0; a < 8; a++) cycle(3'(a), 1'b0, 1'b1, 32'hFFFF_FFFF);

    // Write with ignored upper bits; out_port lags by one edge.
    cycle(3'd0, 1'b1, 1'b0, 32'hFFFF_F3A5);
    cycle(3'd0, 1'b0, 1'b1, 32'h0);

    // SET / CLR / TOGGLE back to back.
    cycle(3'd0, 1'b1, 1'b0, 32'h0F0);
    cycle(3'd1, 1'b1, 1'b0, 32'h003);
    cycle(3'd2, 1'b1, 1'b0, 32'h010);
    cycle(3'd3, 1'b1, 1'b0, 32'h201);
    idle(2, 3'd0);

    // Blink channel 0 with PERIOD=3, then stop and restart with PERIOD=2.
    cycle(3'd0, 1'b1, 1'b0, 32'h3FF);
    cycle(3'd4, 1'b1, 1'b0, 32'h001);
    cycle(3'd5, 1'b1, 1'b0, 32'hAB00_0003);
    idle(14, 3'd6);
    cycle(3'd5, 1'b1, 1'b0, 32'h0);
    idle(5, 3'd6);
    cycle(3'd5, 1'b1, 1'b0, 32'h2);
    idle(8, 3'd6);
    cycle(3'd6, 1'b1, 1'b0, 32'hFFFF_FFFF);
    cycle(3'd7, 1'b1, 1'b0, 32'hFFFF_FFFF);
    cycle(3'd4, 1'b1, 1'b0, 32'h3F0);
    idle(6, 3'd6);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [2:0]  a;
      logic        cs, wn;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 2) != 0);
      wd = $urandom;
      if (a == 3'd5) begin
        wd = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 5));
        if ($urandom_range(0, 3) != 0) wn = 1'b1;
      end
      cycle(a, cs, wn, wd);
    end

    // Asynchronous reset mid-blink.
    cycle(3'd0, 1'b1, 1'b0, 32'h155);
    cycle(3'd4, 1'b1, 1'b0, 32'h155);
    cycle(3'd5, 1'b1, 1'b0, 32'h1);
    idle(5, 3'd6);
    chipselect = 1'b0;
    address    = 3'd0;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("out_port_async_reset", {22'b0, out_port}, 32'h0);
    check("readdata_async_reset", readdata, 32'h0);
    #1 reset_n = 1'b1;
    cycle(3'd0, 1'b1, 1'b0, 32'h155);
    cycle(3'd4, 1'b1, 1'b0, 32'h155);
    idle(8, 3'd6);
    cycle(3'd5, 1'b1, 1'b0, 32'h1);
    idle(8, 3'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
